// File: rtl/axi4_burst_mem_slave.sv
// rtl/axi4_burst_mem_slave.sv - AXI4 burst slave over a word-addressed register memory
// Define AXI_SLV_WRAP_EN to support WRAP bursts; without it every WRAP burst answers SLVERR.
module axi4_burst_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_WORDS          = 256
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic [2:0]                    S_AXI_AWSIZE,
  input  logic [1:0]                    S_AXI_AWBURST,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic [2:0]                    S_AXI_ARSIZE,
  input  logic [1:0]                    S_AXI_ARBURST,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WBURST, WRESP, RBURST} state_t;

  state_t                        r_state;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                    r_len;
  logic [7:0]                    r_beat;
  logic [1:0]                    r_burst;
  logic                          r_err;
  logic                          r_len_err;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
  logic [1:0]                    r_bresp;
  logic                          r_bvalid;
  logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
  logic [31:0]                   r_rdata;
  logic [1:0]                    r_rresp;
  logic                          r_rlast;
  logic                          r_rvalid;
  logic [31:0]                   r_mem [MEM_WORDS];

  logic                          w_aw_hs;
  logic                          w_ar_hs;
  logic                          w_w_hs;
  logic                          w_r_hs;
  logic                          w_aw_wrap_bad;
  logic                          w_ar_wrap_bad;
  logic                          w_aw_err;
  logic                          w_ar_err;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_incr_addr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic [IDX_W-1:0]              w_ar_idx;
  logic [IDX_W-1:0]              w_wr_idx;
  logic [IDX_W-1:0]              w_next_idx;

  assign S_AXI_AWREADY = (r_state == IDLE);
  assign S_AXI_ARREADY = (r_state == IDLE) && !S_AXI_AWVALID;
  assign S_AXI_WREADY  = (r_state == WBURST);
  assign S_AXI_BID     = r_bid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RVALID  = r_rvalid;

  assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign w_r_hs  = r_rvalid && S_AXI_RREADY;

  assign w_incr_addr = r_addr + C_S_AXI_ADDR_WIDTH'(4);

`ifdef AXI_SLV_WRAP_EN
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_wrap_mask;

  assign w_aw_wrap_bad = !((S_AXI_AWLEN == 8'd1) || (S_AXI_AWLEN == 8'd3) ||
                           (S_AXI_AWLEN == 8'd7) || (S_AXI_AWLEN == 8'd15));
  assign w_ar_wrap_bad = !((S_AXI_ARLEN == 8'd1) || (S_AXI_ARLEN == 8'd3) ||
                           (S_AXI_ARLEN == 8'd7) || (S_AXI_ARLEN == 8'd15));
  // Legal wrap lengths make the window mask simply {len[3:0], 2'b11}.
  assign w_wrap_mask = C_S_AXI_ADDR_WIDTH'({r_len[3:0], 2'b11});

  always_comb begin
    w_next_addr = w_incr_addr;
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
      default: w_next_addr = w_incr_addr;
    endcase
  end
`else
  assign w_aw_wrap_bad = 1'b1;
  assign w_ar_wrap_bad = 1'b1;

  always_comb begin
    w_next_addr = w_incr_addr;
    if (r_burst == 2'b00) w_next_addr = r_addr;
  end
`endif

  assign w_aw_err = (S_AXI_AWSIZE != 3'b010) || (S_AXI_AWBURST == 2'b11) ||
                    ((S_AXI_AWBURST == 2'b10) && w_aw_wrap_bad);
  assign w_ar_err = (S_AXI_ARSIZE != 3'b010) || (S_AXI_ARBURST == 2'b11) ||
                    ((S_AXI_ARBURST == 2'b10) && w_ar_wrap_bad);

  assign w_ar_idx   = S_AXI_ARADDR[IDX_W+1:2];
  assign w_wr_idx   = r_addr[IDX_W+1:2];
  assign w_next_idx = w_next_addr[IDX_W+1:2];

  // Memory is deliberately outside the reset domain so its contents survive ARESET.
  always_ff @(posedge ACLK) begin
    if (w_w_hs && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) r_mem[w_wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
      r_len_err <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
      r_bvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= 32'd0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs) begin
            r_bid     <= S_AXI_AWID;
            r_addr    <= S_AXI_AWADDR;
            r_len     <= S_AXI_AWLEN;
            r_burst   <= S_AXI_AWBURST;
            r_beat    <= 8'd0;
            r_err     <= w_aw_err;
            r_len_err <= 1'b0;
            r_state   <= WBURST;
          end else if (w_ar_hs) begin
            r_rid    <= S_AXI_ARID;
            r_addr   <= S_AXI_ARADDR;
            r_len    <= S_AXI_ARLEN;
            r_burst  <= S_AXI_ARBURST;
            r_beat   <= 8'd0;
            r_err    <= w_ar_err;
            r_rvalid <= 1'b1;
            r_rlast  <= (S_AXI_ARLEN == 8'd0);
            r_rdata  <= w_ar_err ? 32'd0 : r_mem[w_ar_idx];
            r_rresp  <= w_ar_err ? 2'b10 : 2'b00;
            r_state  <= RBURST;
          end
        end
        WBURST: begin
          if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_beat <= r_beat + 8'd1;
            if (S_AXI_WLAST) begin
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || r_len_err || (r_beat != r_len)) ? 2'b10 : 2'b00;
              r_state  <= WRESP;
            end else if (r_beat == r_len) begin
              r_len_err <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RBURST: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_rlast <= ((r_beat + 8'd1) == r_len);
              r_rdata <= r_err ? 32'd0 : r_mem[w_next_idx];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// tb/tb_axi4_burst_mem_slave.sv - scoreboard bench for axi4_burst_mem_slave
// Expected read beats come from a bench-side memory model and are queued before each AR.
module tb_axi4_burst_mem_slave;
  localparam int IDW = 4;
  localparam int MW  = 256;
`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic           aclk = 1'b0;
  logic           areset;
  logic [IDW-1:0] awid, arid, bid, rid;
  logic [31:0]    awaddr, araddr, wdata, rdata;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic [3:0]     wstrb;
  logic           awvalid, awready, arvalid, arready, wlast, wvalid, wready;
  logic           bvalid, bready, rlast, rvalid, rready;

  typedef struct {logic [31:0] d; logic [1:0] r; logic l;} exp_t;
  exp_t        exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] model_mem [MW];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 aclk = ~aclk;

  axi4_burst_mem_slave #(
    .C_S_AXI_ID_WIDTH(IDW), .C_S_AXI_ADDR_WIDTH(32), .MEM_WORDS(MW)
  ) dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    if (size != 3'd2 || burst == 2'b11) return 1'b0;
    if (burst == 2'b10)
      return WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return 1'b1;
  endfunction

  function automatic int beat_idx(input logic [31:0] a, input logic [1:0] burst,
                                  input logic [7:0] len, input int beat);
    int unsigned bytes, base, off;
    if (burst == 2'b00) return int'((a >> 2) % MW);
    if (burst == 2'b10) begin
      bytes = (int'(len) + 1) * 4;
      base  = a - (a % bytes);
      off   = (a - base + beat * 4) % bytes;
      return int'(((base + off) >> 2) % MW);
    end
    return int'(((a >> 2) + beat) % MW);
  endfunction

  // Called at a falling edge with the slave idle; consumes its beat data from wq.
  task automatic wr_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [3:0] strb,
                          input int last_beat, input int abort_beat);
    bit ok;
    logic [1:0] exp_resp;
    int idx, cyc;
    ok = legal(size, burst, len);
    exp_resp = (ok && last_beat == int'(len)) ? 2'b00 : 2'b10;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    #1;
    chk("awready_zero_wait", awready, 1);
    cyc = 0;
    while (!awready && cyc < 20) begin @(negedge aclk); #1; cyc++; end
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= last_beat; b++) begin
      wdata = wq.pop_front(); wstrb = strb; wlast = (b == last_beat); wvalid = 1'b1;
      if (b == abort_beat) begin
        areset = 1'b1;
        #1;
        chk("reset_bvalid", bvalid, 0);
        chk("reset_idle", awready, 1);
        @(negedge aclk);
        areset = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        wq.delete();
        return;
      end
      #1;
      chk("wready", wready, 1);
      if (ok) begin
        idx = beat_idx(addr, burst, len, b);
        for (int k = 0; k < 4; k++)
          if (strb[k]) model_mem[idx][8*k +: 8] = wdata[8*k +: 8];
      end
      @(posedge aclk); @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("bvalid_rise", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    chk("bid", bid, id);
    @(negedge aclk); #1;
    chk("bvalid_hold", bvalid, 1);
    chk("bresp_hold", bresp, exp_resp);
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    #1;
    chk("bvalid_drop", bvalid, 0);
    chk("idle_after_b", awready, 1);
    @(negedge aclk);
  endtask

  task automatic rd_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input bit stall);
    bit ok;
    int got, cyc, budget;
    exp_t e;
    ok = legal(size, burst, len);
    for (int b = 0; b <= int'(len); b++) begin
      e.d = ok ? model_mem[beat_idx(addr, burst, len, b)] : 32'h0;
      e.r = ok ? 2'b00 : 2'b10;
      e.l = (b == int'(len));
      exp_q.push_back(e);
    end
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    #1;
    chk("arready_zero_wait", arready, 1);
    cyc = 0;
    while (!arready && cyc < 20) begin @(negedge aclk); #1; cyc++; end
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    got = 0; cyc = 0; budget = 2 * (int'(len) + 1) + 8;
    while (got <= int'(len) && cyc < budget) begin
      rready = stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("rvalid", rvalid, 1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk(rready ? "rdata" : "rdata_stalled", rdata, e.d);
        chk("rresp", rresp, e.r);
        chk("rlast", rlast, e.l);
        chk("rid", rid, id);
        if (rready && rvalid) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      @(posedge aclk); @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    chk("read_beats", got, int'(len) + 1);
    exp_q.delete();
    #1;
    chk("rvalid_drop", rvalid, 0);
    chk("idle_after_r", arready, 1);
    @(negedge aclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    // 16-beat INCR write then 16-beat WRAP read of the same window
    for (int i = 0; i < 16; i++)
      wq.push_back(i == 0 ? 32'hFFFFFFFF : (i == 15 ? 32'h00ABCDEF : $urandom));
    wr_burst(4'd1, 32'h0, 8'd15, 2'b01, 3'd2, 4'hF, 15, -1);
    rd_burst(4'd2, 32'h0, 8'd15, 2'b10, 3'd2, 1'b0);

    // WRAP LEN=3 starting mid-window
    for (int i = 0; i < 4; i++) wq.push_back(32'hA0A0_0000 + i);
    wr_burst(4'd3, 32'h0, 8'd3, 2'b01, 3'd2, 4'hF, 3, -1);
    rd_burst(4'd4, 32'h8, 8'd3, 2'b10, 3'd2, 1'b0);

    // Byte strobes over an all-ones word
    wq.push_back(32'hFFFFFFFF);
    wr_burst(4'd5, 32'h4, 8'd0, 2'b01, 3'd2, 4'hF, 0, -1);
    wq.push_back(32'h12345678);
    wr_burst(4'd6, 32'h4, 8'd0, 2'b01, 3'd2, 4'b0101, 0, -1);
    rd_burst(4'd7, 32'h4, 8'd0, 2'b01, 3'd2, 1'b0);

    // Simultaneous AW and AR: write wins, read waits for the B handshake
    awid = 4'd7; awaddr = 32'h40; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    arid = 4'd8; araddr = 32'h40; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    #1;
    chk("coll_awready", awready, 1);
    chk("coll_arready", arready, 0);
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    wdata = 32'hCAFEBABE; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    model_mem[16] = 32'hCAFEBABE;
    #1;
    chk("coll_arready_w", arready, 0);
    @(posedge aclk); @(negedge aclk);
    wvalid = 1'b0; wlast = 1'b0;
    #1;
    chk("coll_bvalid", bvalid, 1);
    chk("coll_bresp", bresp, 0);
    chk("coll_arready_b", arready, 0);
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    #1;
    chk("coll_arready_idle", arready, 1);
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    #1;
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata", rdata, model_mem[16]);
    chk("coll_rlast", rlast, 1);
    chk("coll_rid", rid, 8);
    rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    rready = 1'b0;
    #1;
    chk("coll_rdone", rvalid, 0);
    @(negedge aclk);

    // 8-beat INCR read with RREADY toggling
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    wr_burst(4'd9, 32'h80, 8'd7, 2'b01, 3'd2, 4'hF, 7, -1);
    rd_burst(4'd10, 32'h80, 8'd7, 2'b01, 3'd2, 1'b1);

    // Early WLAST on beat 2 of LEN=3
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    wr_burst(4'd11, 32'h100, 8'd3, 2'b01, 3'd2, 4'hF, 2, -1);
    rd_burst(4'd12, 32'h100, 8'd2, 2'b01, 3'd2, 1'b0);

    // FIXED bursts hit a single word
    for (int i = 0; i < 4; i++) wq.push_back($urandom);
    wr_burst(4'd13, 32'hC0, 8'd3, 2'b00, 3'd2, 4'hF, 3, -1);
    rd_burst(4'd14, 32'hC0, 8'd2, 2'b00, 3'd2, 1'b0);

    // Bad SIZE write leaves memory untouched; reserved burst read returns zeros
    wq.push_back(32'h11111111); wq.push_back(32'h22222222);
    wr_burst(4'd15, 32'h80, 8'd1, 2'b01, 3'd1, 4'hF, 1, -1);
    rd_burst(4'd1, 32'h80, 8'd1, 2'b01, 3'd2, 1'b0);
    rd_burst(4'd2, 32'h80, 8'd3, 2'b11, 3'd2, 1'b0);

    // INCR index wraps at the top of memory
    wq.push_back(32'h5A5A5A5A); wq.push_back(32'hA5A5A5A5);
    wr_burst(4'd3, 32'h3FC, 8'd1, 2'b01, 3'd2, 4'hF, 1, -1);
    rd_burst(4'd4, 32'h3FC, 8'd1, 2'b01, 3'd2, 1'b1);

    // WRAP write (ignored when wrap support is absent)
    for (int i = 0; i < 4; i++) wq.push_back(32'hB0B0_0000 + i);
    wr_burst(4'd5, 32'h28, 8'd3, 2'b10, 3'd2, 4'hF, 3, -1);
    rd_burst(4'd6, 32'h20, 8'd3, 2'b01, 3'd2, 1'b0);

    // Reset during beat 5 of a 16-beat write
    for (int i = 0; i < 16; i++) wq.push_back(32'hC000_0000 + i);
    wr_burst(4'd6, 32'h200, 8'd15, 2'b01, 3'd2, 4'hF, 15, 5);
    wq.push_back(32'hD00DFEED);
    wr_burst(4'd7, 32'h300, 8'd0, 2'b01, 3'd2, 4'hF, 0, -1);
    rd_burst(4'd8, 32'h200, 8'd4, 2'b01, 3'd2, 1'b0);
    rd_burst(4'd9, 32'h300, 8'd0, 2'b01, 3'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
